// File: rtl/project_select_pkg.sv
// Shared definitions for the project select controller: register offsets,
// FSM state encoding, STATUS/SELECT bit positions and a one-hot helper.
package project_select_pkg;

  // Register offsets, decoded from adr[3:2]
  localparam logic [1:0] REG_SELECT = 2'b00;
  localparam logic [1:0] REG_STATUS = 2'b01;
  localparam logic [1:0] REG_COUNT  = 2'b10;
  localparam logic [1:0] REG_RSVD   = 2'b11;

  typedef enum logic [1:0] {
    StIdle,
    StDrain,
    StEnable
  } state_e;

  // STATUS bit positions
  localparam int unsigned STATUS_BUSY   = 0;
  localparam int unsigned STATUS_ERR    = 1;
  localparam int unsigned STATUS_ID_LSB = 8;
  localparam int unsigned STATUS_ANY    = 31;

  // SELECT layout. The id is kept as the full low byte so an out-of-range id is
  // reported as an error instead of silently aliasing onto a legal project.
  localparam int unsigned SEL_EN_BIT = 31;
  localparam int unsigned SEL_ID_W   = 8;

  // One-hot of id over 32 lanes; ids of 32 and above give all-zero.
  function automatic logic [31:0] onehot(input logic [SEL_ID_W-1:0] id);
    logic [31:0] r;
    r = '0;
    if (id < 8'd32) r[id[4:0]] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/project_select_wb_regs.sv
// Wishbone responder for the project select window.
//   clk_i, rst_ni        clock, async active-low reset
//   wbs_*_i / wbs_*_o    Wishbone responder signals
//   status_i, count_i    read-only register contents from the controller
//   sel_wr_o             one-cycle pulse, asserted in the cycle the SELECT write is accepted
//   sel_en_o, sel_id_o   SELECT value as it will be after that write
module project_select_wb_regs
  import project_select_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                wbs_stb_i,
  input  logic                wbs_cyc_i,
  input  logic                wbs_we_i,
  input  logic [3:0]          wbs_sel_i,
  input  logic [31:0]         wbs_adr_i,
  input  logic [31:0]         wbs_dat_i,
  output logic                wbs_ack_o,
  output logic [31:0]         wbs_dat_o,
  input  logic [31:0]         status_i,
  input  logic [15:0]         count_i,
  output logic                sel_wr_o,
  output logic                sel_en_o,
  output logic [SEL_ID_W-1:0] sel_id_o
);

  logic                ack_q, ack_d;
  logic [31:0]         dat_q, dat_d;
  logic                sel_en_q, sel_en_d;
  logic [SEL_ID_W-1:0] sel_id_q, sel_id_d;
  logic                hit, accept;
  logic [31:0]         rdata;

  assign hit = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
  // Suppressing the cycle after an ack keeps a held strobe from being acked twice.
  assign accept = hit & ~ack_q;

  always_comb begin
    sel_wr_o = accept & wbs_we_i & (wbs_adr_i[3:2] == REG_SELECT);
    sel_en_d = sel_en_q;
    sel_id_d = sel_id_q;
    if (sel_wr_o) begin
      if (wbs_sel_i[0]) sel_id_d = wbs_dat_i[SEL_ID_W-1:0];
      if (wbs_sel_i[3]) sel_en_d = wbs_dat_i[SEL_EN_BIT];
    end

    rdata = '0;
    unique case (wbs_adr_i[3:2])
      REG_SELECT: begin
        rdata[SEL_EN_BIT]   = sel_en_q;
        rdata[SEL_ID_W-1:0] = sel_id_q;
      end
      REG_STATUS: rdata = status_i;
      REG_COUNT:  rdata = {16'h0000, count_i};
      REG_RSVD:   rdata = '0;
      default:    rdata = '0;
    endcase

    ack_d = accept;
    dat_d = accept ? rdata : '0;
  end

  assign sel_en_o  = sel_en_d;
  assign sel_id_o  = sel_id_d;
  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ack_q    <= 1'b0;
      dat_q    <= '0;
      sel_en_q <= 1'b0;
      sel_id_q <= '0;
    end else begin
      ack_q    <= ack_d;
      dat_q    <= dat_d;
      sel_en_q <= sel_en_d;
      sel_id_q <= sel_id_d;
    end
  end

  logic unused_bits;
  assign unused_bits = ^{wbs_adr_i[1:0], wbs_dat_i[30:SEL_ID_W], wbs_sel_i[2:1]};

endmodule

// File: rtl/project_select_ctrl.sv
// Drives the 'active' line of each wrapped project from a firmware-written
// SELECT register. Switches always pass through an all-inactive guard gap.
//   wb_clk_i, wb_rst_ni  clock, async active-low reset
//   wbs_*                Wishbone responder (window BASE_ADDR..BASE_ADDR+0xF)
//   active_o             one-hot (or zero) project active lines
//   busy_o               high while a switch is in progress
module project_select_ctrl
  import project_select_pkg::*;
#(
  parameter int unsigned NUM_PROJECTS = 16,
  parameter logic [31:0] BASE_ADDR    = 32'h3000_0000,
  parameter int unsigned SWITCH_GAP   = 4
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_ni,
  input  logic                    wbs_stb_i,
  input  logic                    wbs_cyc_i,
  input  logic                    wbs_we_i,
  input  logic [3:0]              wbs_sel_i,
  input  logic [31:0]             wbs_adr_i,
  input  logic [31:0]             wbs_dat_i,
  output logic                    wbs_ack_o,
  output logic [31:0]             wbs_dat_o,
  output logic [NUM_PROJECTS-1:0] active_o,
  output logic                    busy_o
);

  localparam int unsigned SEL_W = $clog2(NUM_PROJECTS);
  localparam logic [7:0] GapInit = 8'(SWITCH_GAP);
  localparam logic [SEL_ID_W-1:0] NumLim = SEL_ID_W'(NUM_PROJECTS);

  typedef logic [NUM_PROJECTS-1:0] proj_t;
  typedef logic [SEL_W-1:0]        id_t;

  logic                sel_wr, sel_en;
  logic [SEL_ID_W-1:0] sel_id;
  logic [31:0]         status;

  state_e     state_q, state_d;
  logic [7:0] gap_q, gap_d;
  logic [15:0] count_q, count_d;
  proj_t      active_q, active_d, target_q, target_d, tgt_new;
  logic       err_q, err_d, pend_q, pend_d;
  logic       id_ok;
  id_t        cur_id;

  project_select_wb_regs #(
    .BASE_ADDR (BASE_ADDR)
  ) u_regs (
    .clk_i     (wb_clk_i),
    .rst_ni    (wb_rst_ni),
    .wbs_stb_i (wbs_stb_i),
    .wbs_cyc_i (wbs_cyc_i),
    .wbs_we_i  (wbs_we_i),
    .wbs_sel_i (wbs_sel_i),
    .wbs_adr_i (wbs_adr_i),
    .wbs_dat_i (wbs_dat_i),
    .wbs_ack_o (wbs_ack_o),
    .wbs_dat_o (wbs_dat_o),
    .status_i  (status),
    .count_i   (count_q),
    .sel_wr_o  (sel_wr),
    .sel_en_o  (sel_en),
    .sel_id_o  (sel_id)
  );

  // Target implied by the SELECT value being written this cycle
  always_comb begin
    id_ok   = (sel_id < NumLim);
    tgt_new = '0;
    if (sel_en && id_ok) tgt_new = proj_t'(onehot(sel_id));
  end

  always_comb begin
    cur_id = '0;
    for (int i = 0; i < int'(NUM_PROJECTS); i++) begin
      if (active_q[i]) cur_id = id_t'(i);
    end
    status                         = '0;
    status[STATUS_BUSY]            = (state_q != StIdle);
    status[STATUS_ERR]             = err_q;
    status[STATUS_ID_LSB +: SEL_W] = cur_id;
    status[STATUS_ANY]             = |active_q;
  end

  always_comb begin
    state_d  = state_q;
    gap_d    = gap_q;
    count_d  = count_q;
    active_d = active_q;
    target_d = target_q;
    err_d    = err_q;
    pend_d   = pend_q;

    if (sel_wr) begin
      target_d = tgt_new;
      err_d    = sel_en & ~id_ok;
    end

    unique case (state_q)
      StIdle: begin
        pend_d = 1'b0;
        // pend_q carries a write that arrived during StEnable
        if ((sel_wr || pend_q) && (target_d != active_q)) begin
          state_d  = StDrain;
          gap_d    = GapInit;
          active_d = '0;
        end
      end
      StDrain: begin
        active_d = '0;
        if (sel_wr) begin
          gap_d = GapInit;
        end else if (gap_q == 8'd1) begin
          state_d = StEnable;
        end else begin
          gap_d = gap_q - 8'd1;
        end
      end
      StEnable: begin
        active_d = target_q;
        count_d  = count_q + 16'd1;
        state_d  = StIdle;
        if (sel_wr) pend_d = 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q  <= StIdle;
      gap_q    <= '0;
      count_q  <= '0;
      active_q <= '0;
      target_q <= '0;
      err_q    <= 1'b0;
      pend_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      gap_q    <= gap_d;
      count_q  <= count_d;
      active_q <= active_d;
      target_q <= target_d;
      err_q    <= err_d;
      pend_q   <= pend_d;
    end
  end

  assign active_o = active_q;
  assign busy_o   = (state_q != StIdle);

endmodule

// File: tb/tb_project_select_ctrl.sv
// Bench for project_select_ctrl: Wishbone read data checked by a scoreboard
// monitor, active_o/busy_o timing checked against hand-computed sequences.
module tb_project_select_ctrl;

  localparam int unsigned NP   = 16;
  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam int unsigned GAP  = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          stb = 1'b0, cyc = 1'b0, we = 1'b0;
  logic [3:0]    sel = '0;
  logic [31:0]   adr = '0, wdat = '0;
  logic          ack;
  logic [31:0]   rdat;
  logic [NP-1:0] active;
  logic          busy;

  int checks = 0;
  int errors = 0;
  bit seen_bad = 1'b0;

  typedef struct {
    bit          chk;
    logic [31:0] dat;
  } exp_t;
  exp_t sb_q[$];

  project_select_ctrl #(
    .NUM_PROJECTS (NP),
    .BASE_ADDR    (BASE),
    .SWITCH_GAP   (GAP)
  ) dut (
    .wb_clk_i  (clk),
    .wb_rst_ni (rst_n),
    .wbs_stb_i (stb),
    .wbs_cyc_i (cyc),
    .wbs_we_i  (we),
    .wbs_sel_i (sel),
    .wbs_adr_i (adr),
    .wbs_dat_i (wdat),
    .wbs_ack_o (ack),
    .wbs_dat_o (rdat),
    .active_o  (active),
    .busy_o    (busy)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every ack pops one expected response
  always @(negedge clk) begin
    if (active == 16'h0020 || !$onehot0(active)) seen_bad = 1'b1;
    if (ack) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ack: got ack=1 expected no ack");
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        if (e.chk) check("rd_data", rdat, e.dat);
      end
    end else begin
      check("dat_idle", rdat, 32'h0);
    end
  end

  task automatic xfer(input bit w, input logic [3:0] off, input logic [31:0] d,
                      input logic [3:0] s, input bit chkd, input logic [31:0] expd);
    exp_t e;
    e.chk = chkd;
    e.dat = expd;
    sb_q.push_back(e);
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = w; adr = BASE + {28'h0, off}; wdat = d; sel = s;
    check("ack_early", {31'h0, ack}, 32'h0);
    @(posedge clk); #1;
    check("ack_latency", {31'h0, ack}, 32'h1);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic wr(input logic [3:0] off, input logic [31:0] d, input logic [3:0] s);
    xfer(1'b1, off, d, s, 1'b0, 32'h0);
  endtask

  task automatic rd(input logic [3:0] off, input logic [31:0] expd);
    xfer(1'b0, off, 32'h0, 4'hF, 1'b1, expd);
  endtask

  // Called in the ack cycle: GAP+1 all-zero busy cycles, then the new pattern
  task automatic expect_switch(input logic [NP-1:0] y);
    for (int k = 0; k <= int'(GAP); k++) begin
      check("gap_zero", {16'h0, active}, 32'h0);
      check("gap_busy", {31'h0, busy}, 32'h1);
      @(posedge clk); #1;
    end
    check("new_active", {16'h0, active}, {16'h0, y});
    check("idle_busy", {31'h0, busy}, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    check("rst_active", {16'h0, active}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_ack", {31'h0, ack}, 32'h0);
    #11 rst_n = 1'b1;

    rd(4'h4, 32'h0);
    check("idle_active", {16'h0, active}, 32'h0);

    // Select project 3
    wr(4'h0, 32'h8000_0003, 4'hF);
    expect_switch(16'h0008);
    rd(4'h8, 32'd1);
    rd(4'h4, 32'h8000_0300);
    rd(4'h0, 32'h8000_0003);

    // Retarget during the gap: id 5 never shows, id 7 follows the second ack
    wr(4'h0, 32'h8000_0005, 4'hF);
    check("a1_zero", {16'h0, active}, 32'h0);
    wr(4'h0, 32'h8000_0007, 4'hF);
    expect_switch(16'h0080);
    rd(4'h8, 32'd2);

    // Out-of-range id
    wr(4'h0, 32'h8000_0014, 4'hF);
    expect_switch(16'h0000);
    rd(4'h4, 32'h0000_0002);
    rd(4'h8, 32'd3);
    wr(4'h0, 32'h8000_0001, 4'hF);
    expect_switch(16'h0002);
    rd(4'h4, 32'h8000_0100);
    rd(4'h8, 32'd4);

    // Miss just above the window
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = BASE + 32'h10; wdat = 32'h8000_0007; sel = 4'hF;
    repeat (8) begin
      @(posedge clk); #1;
      check("miss_no_ack", {31'h0, ack}, 32'h0);
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    check("miss_active", {16'h0, active}, 32'h0002);

    // Byte lane 0 only: enable bit retained
    wr(4'h0, 32'h0000_0002, 4'b0001);
    expect_switch(16'h0004);
    rd(4'h0, 32'h8000_0002);
    rd(4'h8, 32'd5);

    // Same target: no switch, no count
    wr(4'h0, 32'h8000_0002, 4'hF);
    check("same_busy", {31'h0, busy}, 32'h0);
    check("same_active", {16'h0, active}, 32'h0004);
    repeat (3) @(posedge clk);
    #1 check("same_active_later", {16'h0, active}, 32'h0004);
    rd(4'h8, 32'd5);

    // Writes to read-only and reserved registers are ignored
    wr(4'hC, 32'hFFFF_FFFF, 4'hF);
    wr(4'h4, 32'hFFFF_FFFF, 4'hF);
    wr(4'h8, 32'hFFFF_FFFF, 4'hF);
    rd(4'hC, 32'h0);
    rd(4'h8, 32'd5);
    rd(4'h4, 32'h8000_0200);

    // Reset during DRAIN
    wr(4'h0, 32'h8000_0009, 4'hF);
    check("pre_rst_busy", {31'h0, busy}, 32'h1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("rst_mid_active", {16'h0, active}, 32'h0);
    check("rst_mid_busy", {31'h0, busy}, 32'h0);
    check("rst_mid_ack", {31'h0, ack}, 32'h0);
    check("rst_mid_dat", rdat, 32'h0);
    #2 rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("post_rst_active", {16'h0, active}, 32'h0);
    check("post_rst_busy", {31'h0, busy}, 32'h0);
    rd(4'h8, 32'h0);
    rd(4'h0, 32'h0);
    rd(4'h4, 32'h0);

    @(posedge clk); #1;
    check("sb_empty", sb_q.size(), 32'h0);
    check("no_bad_active", {31'h0, seen_bad}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
